// File: rtl/scroll_viewport_ctrl.sv
// Viewport controller: latches the rojobot location, derives a clamped viewport
// origin, pans it once per frame, and maps display coordinates onto the world map.
module scroll_viewport_ctrl #(
    parameter int MAP_SIZE    = 256,
    parameter int VIEW_SIZE   = 64,
    parameter int PAN_STEP    = 2,
    parameter int JUMP_THRESH = 48
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        upd_sysregs,
    input  logic [7:0]  LocX_reg,
    input  logic [7:0]  LocY_reg,
    input  logic        frame_tick,
    input  logic [10:0] vid_row,
    input  logic [10:0] vid_col,
    output logic [7:0]  map_row,
    output logic [7:0]  map_col,
    output logic        out_of_view,
    output logic [7:0]  org_x,
    output logic [7:0]  org_y,
    output logic        pan_busy
);

    // SNAP covers the gap between the first target and the frame tick that adopts it.
    localparam logic [1:0] ST_INIT  = 2'd0;
    localparam logic [1:0] ST_SNAP  = 2'd1;
    localparam logic [1:0] ST_TRACK = 2'd2;
    localparam logic [1:0] ST_PAN   = 2'd3;

    localparam logic signed [8:0] HALF_S  = 9'(VIEW_SIZE / 2);
    localparam logic signed [8:0] MAXO_S  = 9'(MAP_SIZE - VIEW_SIZE);
    localparam logic [8:0]        JUMP_U  = 9'(JUMP_THRESH);
    localparam logic [8:0]        STEP_U  = 9'(PAN_STEP);
    localparam logic [7:0]        STEP_8  = 8'(PAN_STEP);
    localparam logic [10:0]       VIEW_11 = 11'(VIEW_SIZE);

    logic [1:0] state_q, state_d;
    logic [7:0] tgt_x_q, tgt_x_d, tgt_y_q, tgt_y_d;
    logic [7:0] org_x_q, org_x_d, org_y_q, org_y_d;
    logic [7:0] map_row_q, map_row_d, map_col_q, map_col_d;
    logic       oov_q, oov_d;
    logic       pan_busy_q;
    logic [7:0] step_x_s, step_y_s;

    function automatic logic [7:0] clamp_org(input logic [7:0] loc);
        logic signed [8:0] d;
        d = $signed({1'b0, loc}) - HALF_S;
        if (d < 9'sd0) begin
            return 8'd0;
        end else if (d > MAXO_S) begin
            return MAXO_S[7:0];
        end else begin
            return d[7:0];
        end
    endfunction

    function automatic logic [7:0] pan_next(input logic [7:0] org, input logic [7:0] tgt);
        logic signed [8:0] err;
        logic [8:0]        mag;
        err = $signed({1'b0, tgt}) - $signed({1'b0, org});
        mag = err[8] ? (~err + 9'd1) : err;
        if ((mag > JUMP_U) || (mag <= STEP_U)) begin
            return tgt;
        end else if (err[8]) begin
            return org - STEP_8;
        end else begin
            return org + STEP_8;
        end
    endfunction

    assign step_x_s = pan_next(org_x_q, tgt_x_q);
    assign step_y_s = pan_next(org_y_q, tgt_y_q);

    // Target latch and origin/FSM next state; a tick always acts on the old target.
    always_comb begin
        state_d = state_q;
        tgt_x_d = tgt_x_q;
        tgt_y_d = tgt_y_q;
        org_x_d = org_x_q;
        org_y_d = org_y_q;
        if (upd_sysregs) begin
            tgt_x_d = clamp_org(LocX_reg);
            tgt_y_d = clamp_org(LocY_reg);
        end else begin
            tgt_x_d = tgt_x_q;
            tgt_y_d = tgt_y_q;
        end
        case (state_q)
            ST_INIT: begin
                if (upd_sysregs) state_d = ST_SNAP;
                else             state_d = ST_INIT;
            end
            ST_SNAP: begin
                if (frame_tick) begin
                    org_x_d = tgt_x_q;
                    org_y_d = tgt_y_q;
                    state_d = ST_TRACK;
                end else begin
                    state_d = ST_SNAP;
                end
            end
            ST_TRACK: begin
                if ((tgt_x_q != org_x_q) || (tgt_y_q != org_y_q)) state_d = ST_PAN;
                else                                               state_d = ST_TRACK;
            end
            ST_PAN: begin
                if (frame_tick) begin
                    org_x_d = step_x_s;
                    org_y_d = step_y_s;
                    if ((step_x_s == tgt_x_q) && (step_y_s == tgt_y_q)) state_d = ST_TRACK;
                    else                                                 state_d = ST_PAN;
                end else begin
                    state_d = ST_PAN;
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    // Address translation; out-of-view pixels park on the origin.
    always_comb begin
        oov_d = (vid_row >= VIEW_11) || (vid_col >= VIEW_11);
        if (oov_d) begin
            map_row_d = org_y_q;
            map_col_d = org_x_q;
        end else begin
            map_row_d = org_y_q + vid_row[7:0];
            map_col_d = org_x_q + vid_col[7:0];
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_INIT;
            tgt_x_q    <= 8'd0;
            tgt_y_q    <= 8'd0;
            org_x_q    <= 8'd0;
            org_y_q    <= 8'd0;
            map_row_q  <= 8'd0;
            map_col_q  <= 8'd0;
            oov_q      <= 1'b0;
            pan_busy_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            tgt_x_q    <= tgt_x_d;
            tgt_y_q    <= tgt_y_d;
            org_x_q    <= org_x_d;
            org_y_q    <= org_y_d;
            map_row_q  <= map_row_d;
            map_col_q  <= map_col_d;
            oov_q      <= oov_d;
            pan_busy_q <= (state_d == ST_PAN);
        end
    end

    assign map_row     = map_row_q;
    assign map_col     = map_col_q;
    assign out_of_view = oov_q;
    assign org_x       = org_x_q;
    assign org_y       = org_y_q;
    assign pan_busy    = pan_busy_q;

endmodule

// File: tb/tb_scroll_viewport_ctrl.sv
// Directed bench for scroll_viewport_ctrl with hand-computed expected values.
module tb_scroll_viewport_ctrl;

    logic        clk;
    logic        reset;
    logic        upd_sysregs;
    logic [7:0]  LocX_reg;
    logic [7:0]  LocY_reg;
    logic        frame_tick;
    logic [10:0] vid_row;
    logic [10:0] vid_col;
    logic [7:0]  map_row;
    logic [7:0]  map_col;
    logic        out_of_view;
    logic [7:0]  org_x;
    logic [7:0]  org_y;
    logic        pan_busy;

    int n_total = 0;
    int n_bad   = 0;

    scroll_viewport_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .upd_sysregs (upd_sysregs),
        .LocX_reg    (LocX_reg),
        .LocY_reg    (LocY_reg),
        .frame_tick  (frame_tick),
        .vid_row     (vid_row),
        .vid_col     (vid_col),
        .map_row     (map_row),
        .map_col     (map_col),
        .out_of_view (out_of_view),
        .org_x       (org_x),
        .org_y       (org_y),
        .pan_busy    (pan_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d want=%0d", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_upd(input logic [7:0] x, input logic [7:0] y);
        upd_sysregs = 1'b1;
        LocX_reg    = x;
        LocY_reg    = y;
        cyc(1);
        upd_sysregs = 1'b0;
    endtask

    task automatic pulse_tick();
        frame_tick = 1'b1;
        cyc(1);
        frame_tick = 1'b0;
    endtask

    initial begin
        reset       = 1'b1;
        upd_sysregs = 1'b0;
        LocX_reg    = 8'd0;
        LocY_reg    = 8'd0;
        frame_tick  = 1'b0;
        vid_row     = 11'd0;
        vid_col     = 11'd0;
        cyc(3);
        chk("rst_org_x", org_x, 0);
        chk("rst_org_y", org_y, 0);
        chk("rst_busy", pan_busy, 0);
        chk("rst_oov", out_of_view, 0);
        reset = 1'b0;
        cyc(2);

        // Initial snap to (68, 0)
        pulse_upd(8'd100, 8'd20);
        cyc(2);
        chk("init_no_tick", org_x, 0);
        pulse_tick();
        cyc(1);
        chk("snap_x", org_x, 68);
        chk("snap_y", org_y, 0);
        chk("snap_busy", pan_busy, 0);
        vid_row = 11'd5;
        vid_col = 11'd10;
        cyc(1);
        chk("addr_row", map_row, 5);
        chk("addr_col", map_col, 78);
        chk("addr_oov", out_of_view, 0);

        // Smooth pan 68 -> 78
        pulse_upd(8'd110, 8'd20);
        cyc(1);
        chk("pan_busy_up", pan_busy, 1);
        chk("pan_start_x", org_x, 68);
        for (int k = 1; k <= 5; k++) begin
            cyc(3);
            chk("pan_hold", org_x, 68 + 2 * (k - 1));
            pulse_tick();
            chk("pan_step", org_x, 68 + 2 * k);
            chk("pan_busy", pan_busy, (k < 5) ? 1 : 0);
        end
        cyc(1);
        chk("pan_addr_col", map_col, 88);

        // Out-of-view boundaries
        vid_row = 11'd0;
        vid_col = 11'd64;
        cyc(1);
        chk("oov_col64", out_of_view, 1);
        chk("oov_col64_map", map_col, 78);
        vid_col = 11'd63;
        cyc(1);
        chk("oov_col63", out_of_view, 0);
        chk("col63_map", map_col, 141);
        vid_row = 11'd64;
        vid_col = 11'd0;
        cyc(1);
        chk("oov_row64", out_of_view, 1);
        chk("oov_row64_map", map_row, 0);
        vid_row = 11'd0;

        // Pan toward 68, retarget to 78, then simultaneous update to 28
        pulse_upd(8'd100, 8'd20);
        cyc(1);
        chk("re_busy", pan_busy, 1);
        pulse_tick();
        chk("re_76", org_x, 76);
        pulse_tick();
        chk("re_74", org_x, 74);
        pulse_upd(8'd110, 8'd20);
        cyc(1);
        chk("retgt_hold", org_x, 74);
        upd_sysregs = 1'b1;
        LocX_reg    = 8'd60;
        LocY_reg    = 8'd20;
        frame_tick  = 1'b1;
        cyc(1);
        upd_sysregs = 1'b0;
        frame_tick  = 1'b0;
        chk("simul_old_tgt", org_x, 76);
        pulse_tick();
        chk("simul_new_tgt", org_x, 74);
        chk("simul_busy", pan_busy, 1);

        // Asynchronous reset mid-pan
        reset = 1'b1;
        #2;
        chk("arst_org_x", org_x, 0);
        chk("arst_busy", pan_busy, 0);
        cyc(1);
        reset = 1'b0;
        pulse_tick();
        cyc(2);
        chk("init_tick_ignored", org_x, 0);

        // Clamp high via snap, then jump rule while panning
        pulse_upd(8'd250, 8'd3);
        pulse_tick();
        chk("clamp_x192", org_x, 192);
        chk("clamp_y0", org_y, 0);
        cyc(1);
        pulse_upd(8'd0, 8'd250);
        cyc(1);
        chk("jump_busy", pan_busy, 1);
        pulse_tick();
        chk("jump_x0", org_x, 0);
        chk("jump_y192", org_y, 192);
        chk("jump_done", pan_busy, 0);
        cyc(1);
        pulse_upd(8'd33, 8'd224);
        cyc(1);
        pulse_tick();
        chk("edge_x1", org_x, 1);
        chk("edge_y192", org_y, 192);
        chk("edge_busy", pan_busy, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
